mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Sole owner of the cpu's byte-wide RAM port (mem_a/mem_dout/mem_din/mem_wr).
//  Arbitrates instruction fetch (IF) and load/store (LS) requesters and serialises
//  their 1/2/4-byte little-endian accesses into byte cycles on the synchronous RAM
//  (1-cycle read latency). Sits inside cpu, between the pipeline and the RAM port.
// PARAMETERS
//  ADDR_WIDTH  32  width of all address buses; byte addresses wrap modulo 2^ADDR_WIDTH
//  LS_FIRST    1   1: LS wins simultaneous requests; 0: IF wins
// PORTS
//  clk_in     in   1   system clock
//  rst_in     in   1   asynchronous reset, active-high
//  rdy_in     in   1   0 = freeze: no state, counter or output register changes
//  if_req     in   1   IF read request, held until if_done
//  if_addr    in   32  IF word address
//  if_flush   in   1   abort pending/in-flight IF access
//  if_done    out  1   1-cycle pulse, if_data valid
//  if_data    out  32  fetched word
//  ls_req     in   1   LS request, held until ls_done
//  ls_wr      in   1   1 = store, 0 = load
//  ls_size    in   2   00=1B 01=2B 10=4B 11=4B (reserved, treated as 4B)
//  ls_addr    in   32  LS byte address
//  ls_wdata   in   32  store data; byte k = ls_wdata[8k+7:8k]
//  ls_done    out  1   1-cycle pulse; ls_rdata valid on loads
//  ls_rdata   out  32  load data, zero-extended (sign-extension is the pipeline's job)
//  mem_din    in   8   RAM read byte
//  mem_dout   out  8   RAM write byte
//  mem_a      out  32  RAM byte address
//  mem_wr     out  1   1 = write
// BEHAVIOUR
//  Reset (async): state IDLE; mem_a=0, mem_dout=0, mem_wr=0, if_done=0, ls_done=0,
//   if_data=0, ls_rdata=0, byte counter 0. Reset mid-access abandons it; no done pulse.
//  All outputs are registered. Every rule below applies only at edges with rdy_in=1;
//   with rdy_in=0 everything holds (a held mem_wr=1 rewrites the same byte, harmless).
//  States: IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: accept at edge E0 when a req is high (LS_FIRST decides ties); latch
//   owner/addr/size/wr/wdata; drive mem_a=addr, mem_wr=wr, mem_dout=byte0.
//  BUSY read of n bytes: mem_a = addr+k after edge Ek (k<n); byte k captured from
//   mem_din at E(k+2) into lane k. At E(n+1): DONE, done=1. Latency n+1 cycles
//   (IF word = 5).
//  BUSY write of n bytes: byte k driven with mem_wr=1 after Ek. At En: mem_wr=0,
//   DONE, done=1. Latency n cycles. IF never writes.
//  DONE: done high exactly one cycle; no accept in this cycle; next edge -> IDLE.
//   Earliest next accept is the edge after that (requester drops req on seeing done).
//  Idle outputs: mem_wr=0; mem_a holds the last value.
//  Flush: if_flush=1 at an edge while owner=IF (BUSY/DONE) -> IDLE, mem_wr=0, if_done=0.
//   if_flush=1 in IDLE blocks IF acceptance that edge; LS is unaffected.
//  Address increment is ADDR_WIDTH-bit with wrap: 0xFFFFFFFF+1 = 0.
//  Non-owner done stays 0; unused lanes of a short load read 0.
//  No starvation guard: the losing requester waits until the winner drops req.
// STRUCTURE
//  Shared header mem_defs.vh: size codes (SZ_B/SZ_H/SZ_W), state codes, byte-count fn.
//  One sub-module, mem_byte_seq: byte counter, address increment, lane capture and
//   drive; start/size/wr in, last/data out. mem_ctrl keeps arbitration, flush, done.
// TESTING
//  1 IF-only: preload RAM[0..3]=13 00 00 93, if_addr=0 -> if_done 5 cycles after
//    accept, if_data=0x93000013.
//  2 LS store size=10, addr=0x100, wdata=0xDEADBEEF -> bytes EF BE AD DE at 0x100..0x103,
//    ls_done after 4 cycles; load back -> ls_rdata=0xDEADBEEF.
//  3 if_req and ls_req (load byte 0x103) in same cycle, LS_FIRST=1 -> ls_done first,
//    ls_rdata=0x000000DE; IF accepted 2 cycles after ls_done.
//  4 IF in flight, if_flush pulse at byte 2 -> no if_done, state IDLE next cycle;
//    a fresh if_addr=4 completes normally.
//  5 rdy_in=0 for 3 cycles mid LS load halfword -> completion delayed exactly 3 cycles,
//    data correct; rst_in pulse mid access -> all outputs 0, no done.
//  6 halfword load at 0xFFFFFFFF -> bytes from 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared size codes, controller states, owner encoding and the
//            access-size to byte-count helper for the memory controller.
// Revision : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

  localparam logic [1:0] c_sz_b = 2'b00;
  localparam logic [1:0] c_sz_h = 2'b01;
  localparam logic [1:0] c_sz_w = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Reserved size code 11 is handled as a full word.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      c_sz_b:  return 3'd1;
      c_sz_h:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_byte_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_byte_seq
// Purpose  : Byte sequencer for the RAM port: counts bytes, steps the address
//            with wrap, drives store bytes and assembles load lanes.
// Revision : 1.0  initial release
// ============================================================================
module mem_ctrl_byte_seq
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  start,
  input  logic                  step,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            size,
  input  logic                  wr,
  input  logic [31:0]           wdata,
  input  logic [7:0]            mem_din,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr,
  output logic                  last,
  output logic [31:0]           data
);

  logic [ADDR_WIDTH-1:0] r_base;
  logic [31:0]           r_wdata;
  logic [31:0]           r_data;
  logic [2:0]            r_n;
  logic [2:0]            r_cnt;
  logic                  r_wr;
  logic                  r_rdy_prev;
  logic [7:0]            r_din_hold;

  logic [2:0] w_cnt_inc;
  logic [1:0] w_lane;
  logic       w_more;
  logic [7:0] w_din;

  assign w_cnt_inc = r_cnt + 3'd1;
  assign w_lane    = r_cnt[1:0] - 2'd1;
  assign w_more    = (w_cnt_inc < r_n);
  // Loads finish one edge after the last byte's data returns; stores finish
  // on the edge that retires the last written byte.
  assign last      = r_wr ? (w_cnt_inc == r_n) : (r_cnt == r_n);

  // The RAM keeps reading the held address while frozen, so the byte that
  // belonged to the last active edge is parked and used on the resume edge.
  assign w_din = r_rdy_prev ? mem_din : r_din_hold;

  // Load lane assembly: lane cnt-1 receives the byte returning this cycle.
  always_comb begin
    data = r_data;
    if (!r_wr && (r_cnt != 3'd0)) begin
      data[{w_lane, 3'b000} +: 8] = w_din;
    end
  end

  // Tracks whether the previous edge was active and parks the returning byte.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rdy_prev <= 1'b1;
      r_din_hold <= 8'h00;
    end else begin
      r_rdy_prev <= rdy_in;
      if (r_rdy_prev) begin
        r_din_hold <= mem_din;
      end
    end
  end

  // Byte counter, address stepping and RAM port drive.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_base   <= '0;
      r_wdata  <= 32'h0;
      r_data   <= 32'h0;
      r_n      <= 3'd0;
      r_cnt    <= 3'd0;
      r_wr     <= 1'b0;
      mem_a    <= '0;
      mem_dout <= 8'h00;
      mem_wr   <= 1'b0;
    end else if (rdy_in) begin
      if (abort) begin
        mem_wr <= 1'b0;
      end else if (start) begin
        r_base   <= addr;
        r_n      <= byte_count(size);
        r_wr     <= wr;
        r_wdata  <= wdata;
        r_cnt    <= 3'd0;
        r_data   <= 32'h0;
        mem_a    <= addr;
        mem_wr   <= wr;
        mem_dout <= wdata[7:0];
      end else if (step) begin
        r_data <= data;
        r_cnt  <= w_cnt_inc;
        if (w_more) begin
          mem_a    <= r_base + ADDR_WIDTH'(w_cnt_inc);
          mem_dout <= r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];
        end else begin
          mem_wr <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Owner of the byte-wide RAM port. Arbitrates instruction fetch
//            and load/store requests, handles fetch flush and done pulses.
// Revision : 1.0  initial release
// ============================================================================
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LS_FIRST   = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  ls_req,
  input  logic                  ls_wr,
  input  logic [1:0]            ls_size,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  state_t r_state;
  state_t w_state_nxt;
  owner_t r_owner;

  logic w_if_ok;
  logic w_grant_ls;
  logic w_start;
  logic w_step;
  logic w_abort;
  logic w_finish;
  logic w_seq_last;
  logic [31:0] w_seq_data;
  logic [ADDR_WIDTH-1:0] w_seq_addr;
  logic [1:0] w_seq_size;
  logic w_seq_wr;

  // A flush in the accept cycle keeps the fetch from being taken.
  assign w_if_ok    = if_req && !if_flush;
  assign w_seq_addr = w_grant_ls ? ls_addr : if_addr;
  assign w_seq_size = w_grant_ls ? ls_size : c_sz_w;
  assign w_seq_wr   = w_grant_ls && ls_wr;

  // Arbitration, flush and sequencing decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_ls  = 1'b0;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_abort     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ls_req && ((LS_FIRST != 0) || !w_if_ok)) begin
          w_grant_ls  = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = ST_BUSY;
        end else if (w_if_ok) begin
          w_start     = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if ((r_owner == OWN_IF) && if_flush) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (w_seq_last) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, owner and registered completion outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= ST_IDLE;
      r_owner  <= OWN_IF;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= 32'h0;
      ls_rdata <= 32'h0;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_owner <= w_grant_ls ? OWN_LS : OWN_IF;
      end
      if_done <= w_finish && (r_owner == OWN_IF);
      ls_done <= w_finish && (r_owner == OWN_LS);
      if (w_finish && (r_owner == OWN_IF)) begin
        if_data <= w_seq_data;
      end
      if (w_finish && (r_owner == OWN_LS)) begin
        ls_rdata <= w_seq_data;
      end
    end
  end

  mem_ctrl_byte_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_seq (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .start   (w_start),
    .step    (w_step),
    .abort   (w_abort),
    .addr    (w_seq_addr),
    .size    (w_seq_size),
    .wr      (w_seq_wr),
    .wdata   (ls_wdata),
    .mem_din (mem_din),
    .mem_a   (mem_a),
    .mem_dout(mem_dout),
    .mem_wr  (mem_wr),
    .last    (w_seq_last),
    .data    (w_seq_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Scoreboard bench for mem_ctrl with a byte-addressed reference
//            memory, directed scenarios and randomized traffic with stalls.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;

  localparam int c_tmo = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  // RAM model: 4 KiB indexed by the low address bits, 1-cycle read latency.
  logic [7:0]  ram [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic        ram_init;
  logic        pl_en;
  logic [11:0] pl_a;
  logic [7:0]  pl_d;

  int checks = 0;
  int failures = 0;

  logic [31:0] if_q [$];
  logic [32:0] ls_q [$];

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_WIDTH(32), .LS_FIRST(1)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // Synchronous RAM: write-through on mem_wr, registered read.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'(i * 7 + 3);
    end else if (pl_en) begin
      ram[pl_a] <= pl_d;
    end else if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
    end
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] v = 32'h0;
    logic [31:0] b;
    for (int k = 0; k < n; k++) begin
      b = a + 32'(k);
      v[8*k +: 8] = ref_mem[b[11:0]];
    end
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a, input int n, input logic [31:0] d);
    logic [31:0] b;
    for (int k = 0; k < n; k++) begin
      b = a + 32'(k);
      ref_mem[b[11:0]] = d[8*k +: 8];
    end
  endtask

  task automatic expect_if(input logic [31:0] a);
    if_q.push_back(ref_read(a, 4));
  endtask

  task automatic expect_ls(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d);
    if (wr) begin
      ref_write(a, nbytes(sz), d);
      ls_q.push_back({1'b0, 32'h0});
    end else begin
      ls_q.push_back({1'b1, ref_read(a, nbytes(sz))});
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    pl_a = a[11:0];
    pl_d = d;
    pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[a[11:0]] = d;
  endtask

  // Holds if_req until if_done; cyc counts negedges from request to done.
  task automatic run_if(input logic [31:0] a, output int cyc);
    if_addr = a;
    if_req = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!if_done && cyc < c_tmo);
    if_req = 1'b0;
    if (!if_done) check32("if_timeout", 32'(cyc), 32'(c_tmo + 1));
  endtask

  task automatic run_ls(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output int cyc);
    ls_wr = wr;
    ls_size = sz;
    ls_addr = a;
    ls_wdata = d;
    ls_req = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ls_done && cyc < c_tmo);
    ls_req = 1'b0;
    if (!ls_done) check32("ls_timeout", 32'(cyc), 32'(c_tmo + 1));
  endtask

  task automatic check_outputs_zero(input string tag);
    check32({tag, "_mem_a"}, mem_a, 32'h0);
    check32({tag, "_mem_dout"}, {24'h0, mem_dout}, 32'h0);
    check32({tag, "_mem_wr"}, {31'h0, mem_wr}, 32'h0);
    check32({tag, "_if_done"}, {31'h0, if_done}, 32'h0);
    check32({tag, "_ls_done"}, {31'h0, ls_done}, 32'h0);
    check32({tag, "_if_data"}, if_data, 32'h0);
    check32({tag, "_ls_rdata"}, ls_rdata, 32'h0);
  endtask

  // Monitor: a done pulse held across frozen edges counts once.
  bit prev_if = 1'b0;
  bit prev_ls = 1'b0;
  bit edge_rdy;
  logic [31:0] mon_if_exp;
  logic [32:0] mon_ls_exp;
  initial begin
    forever begin
      @(posedge clk);
      edge_rdy = rdy;
      @(negedge clk);
      if (if_done && ls_done) check32("both_done", 32'h1, 32'h0);
      if (if_done && (!prev_if || edge_rdy)) begin
        if (if_q.size() == 0) begin
          check32("if_unexpected_done", 32'h1, 32'h0);
        end else begin
          mon_if_exp = if_q.pop_front();
          check32("if_data", if_data, mon_if_exp);
        end
      end
      if (ls_done && (!prev_ls || edge_rdy)) begin
        if (ls_q.size() == 0) begin
          check32("ls_unexpected_done", 32'h1, 32'h0);
        end else begin
          mon_ls_exp = ls_q.pop_front();
          if (mon_ls_exp[32]) check32("ls_rdata", ls_rdata, mon_ls_exp[31:0]);
        end
      end
      prev_if = if_done;
      prev_ls = ls_done;
    end
  end

  int c1, c2, kind, saw;
  bit stall, done_flag;
  logic [31:0] ra, ia, wd;
  logic [1:0]  sz;
  logic        w;

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return 32'h200 + 32'($urandom_range(0, 511));
  endfunction

  initial begin
    rst = 1'b1; rdy = 1'b1;
    if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'b00; ls_addr = 32'h0; ls_wdata = 32'h0;
    pl_en = 1'b0; pl_a = 12'h0; pl_d = 8'h0; ram_init = 1'b1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i * 7 + 3);
    repeat (2) @(negedge clk);
    ram_init = 1'b0;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: word fetch
    preload(32'h0, 8'h13); preload(32'h1, 8'h00);
    preload(32'h2, 8'h00); preload(32'h3, 8'h93);
    expect_if(32'h0);
    run_if(32'h0, c1);
    check32("t1_latency", 32'(c1), 32'd6);
    check32("t1_if_data", if_data, 32'h9300_0013);
    @(negedge clk);

    // 2: word store then load back
    expect_ls(1'b1, 2'b10, 32'h100, 32'hDEAD_BEEF);
    run_ls(1'b1, 2'b10, 32'h100, 32'hDEAD_BEEF, c1);
    check32("t2_st_latency", 32'(c1), 32'd5);
    @(negedge clk);
    check32("t2_ram", {ram[12'h103], ram[12'h102], ram[12'h101], ram[12'h100]}, 32'hDEAD_BEEF);
    expect_ls(1'b0, 2'b10, 32'h100, 32'h0);
    run_ls(1'b0, 2'b10, 32'h100, 32'h0, c1);
    check32("t2_ld_latency", 32'(c1), 32'd6);
    check32("t2_ls_rdata", ls_rdata, 32'hDEAD_BEEF);
    @(negedge clk);

    // 3: simultaneous requests, load store unit wins
    expect_ls(1'b0, 2'b00, 32'h103, 32'h0);
    expect_if(32'h0);
    fork
      run_ls(1'b0, 2'b00, 32'h103, 32'h0, c1);
      run_if(32'h0, c2);
    join
    check32("t3_ls_latency", 32'(c1), 32'd3);
    check32("t3_if_after_ls", 32'(c2), 32'(c1 + 2 + 5));
    check32("t3_ls_rdata", ls_rdata, 32'h0000_00DE);
    @(negedge clk);

    // 4: fetch flushed at byte 2, then a fresh fetch
    if_addr = 32'h10;
    if_req = 1'b1;
    repeat (3) @(negedge clk);
    check32("t4_mem_a_byte2", mem_a, 32'h12);
    if_flush = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    if_flush = 1'b0;
    check32("t4_no_done", {31'h0, if_done}, 32'h0);
    expect_if(32'h4);
    run_if(32'h4, c1);
    check32("t4_refetch_latency", 32'(c1), 32'd6);
    @(negedge clk);

    // 5: freeze mid halfword load, then reset mid access
    expect_ls(1'b0, 2'b01, 32'h100, 32'h0);
    fork
      run_ls(1'b0, 2'b01, 32'h100, 32'h0, c1);
      begin
        repeat (2) @(negedge clk);
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        rdy = 1'b1;
      end
    join
    check32("t5_freeze_latency", 32'(c1), 32'd7);
    check32("t5_ls_rdata", ls_rdata, 32'h0000_BEEF);
    @(negedge clk);
    ls_wr = 1'b0; ls_size = 2'b10; ls_addr = 32'h104; ls_req = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("t5_midrst");
    @(negedge clk);
    ls_req = 1'b0;
    rst = 1'b0;
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (ls_done || if_done) saw++;
    end
    check32("t5_no_done_after_rst", 32'(saw), 32'd0);

    // 6: halfword access across the address wrap
    preload(32'hFFFF_FFFF, 8'hA5);
    preload(32'h0, 8'h3C);
    expect_ls(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0);
    run_ls(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0, c1);
    check32("t6_latency", 32'(c1), 32'd4);
    check32("t6_ls_rdata", ls_rdata, 32'h0000_3CA5);
    @(negedge clk);
    expect_ls(1'b1, 2'b01, 32'hFFFF_FFFF, 32'h0000_1234);
    run_ls(1'b1, 2'b01, 32'hFFFF_FFFF, 32'h0000_1234, c1);
    @(negedge clk);
    check32("t6_ram_wrap", {16'h0, ram[12'h000], ram[12'hFFF]}, 32'h0000_1234);

    // Randomized traffic with optional freeze cycles
    for (int it = 0; it < 120; it++) begin
      stall = ($urandom_range(0, 2) == 0);
      kind  = $urandom_range(0, 2);
      ra    = rand_addr();
      ia    = rand_addr() & ~32'h3;
      wd    = $urandom();
      sz    = 2'($urandom_range(0, 3));
      w     = 1'($urandom_range(0, 1));
      if (kind != 0) expect_ls(w, sz, ra, wd);
      if (kind != 1) expect_if(ia);
      done_flag = 1'b0;
      fork
        begin
          if (kind == 0) run_if(ia, c1);
          else if (kind == 1) run_ls(w, sz, ra, wd, c1);
          else fork
            run_ls(w, sz, ra, wd, c1);
            run_if(ia, c2);
          join
          done_flag = 1'b1;
        end
        begin
          while (!done_flag) begin
            @(negedge clk);
            if (stall && !done_flag) rdy = ($urandom_range(0, 3) != 0);
          end
        end
      join
      rdy = 1'b1;
      if (!stall && kind == 0) check32("rnd_if_latency", 32'(c1), 32'd6);
      if (!stall && kind == 1)
        check32("rnd_ls_latency", 32'(c1), 32'(w ? nbytes(sz) + 1 : nbytes(sz) + 2));
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 4096; i++) begin
      if (ram[i] !== ref_mem[i]) check32("ram_contents", {20'h0, 12'(i)}, 32'hFFFF_FFFF);
      else checks++;
    end
    check32("if_q_empty", 32'(if_q.size()), 32'd0);
    check32("ls_q_empty", 32'(ls_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
